// File: rtl/aes_pkg.sv
// Shared AES types, constants and byte/column transforms for the round engine.
// Blocks use FIPS-197 column-major byte order: byte k = bits [8k:8k+7], column c = bytes 4c..4c+3.
package aes_pkg;

  localparam int aes_nr_gp = 14;
  localparam int aes_nb_gp = 4;

  typedef logic [0:127] aes_block_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  // Forward S-box; entry b occupies bits [8b:8b+7].
  localparam logic [0:2047] sbox_gp = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_f(input logic [7:0] b);
    return sbox_gp[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime_f(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_block_t shift_rows_f(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int c = 0; c < aes_nb_gp; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic aes_block_t mix_columns_f(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < aes_nb_gp; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime_f(a0) ^ xtime_f(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime_f(a1) ^ xtime_f(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime_f(a2) ^ xtime_f(a3) ^ a3;
      o[32*c+24 +: 8] = xtime_f(a0) ^ a0 ^ a1 ^ a2 ^ xtime_f(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; the final round bypasses MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  aes_block_t state_i,
  input  aes_block_t rk_i,
  input  logic       final_i,
  output aes_block_t state_o
);

  aes_block_t w_sub;
  aes_block_t w_shift;
  aes_block_t w_mix;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_sub = '0;
    for (int k = 0; k < 16; k++) begin
      w_sub[8*k +: 8] = sbox_f(state_i[8*k +: 8]);
    end
  end

  assign w_shift = shift_rows_f(w_sub);
  assign w_mix   = mix_columns_f(w_shift);
  assign state_o = (final_i ? w_shift : w_mix) ^ rk_i;

endmodule

// File: rtl/aes256_round_engine.sv
// Multicycle AES-256 encryptor: one round per clock on a latched block, keys taken live from key_expansion.
module aes256_round_engine
  import aes_pkg::*;
#(
  parameter int num_rounds_p = aes_nr_gp
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              v_i,
  output logic              ready_o,
  input  logic [0:127]      plaintext_i,
  input  logic [0:128*15-1] round_keys_i,
  output logic              v_o,
  output logic [0:127]      ciphertext_o,
  input  logic              yumi_i
);

  if (num_rounds_p != aes_nr_gp) begin : g_bad_rounds
    $error("aes256_round_engine: num_rounds_p must be 14");
  end

  aes_fsm_e   fsm_r, w_fsm_next;
  logic [3:0] round_r;
  aes_block_t state_r;
  aes_block_t w_rk;
  aes_block_t w_round_out;
  logic       w_final;
  logic       w_accept;

  always_comb begin
    w_rk = '0;
    for (int r = 1; r <= aes_nr_gp; r++) begin
      if (round_r == 4'(r)) w_rk = round_keys_i[128*r +: 128];
    end
  end

  aes_round u_round (
    .state_i (state_r),
    .rk_i    (w_rk),
    .final_i (w_final),
    .state_o (w_round_out)
  );

  always_comb begin
    w_fsm_next = fsm_r;
    ready_o    = 1'b0;
    v_o        = 1'b0;
    w_accept   = 1'b0;
    w_final    = (round_r == 4'(num_rounds_p));
    case (fsm_r)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          w_accept   = 1'b1;
          w_fsm_next = BUSY;
        end
      end
      BUSY:    if (w_final) w_fsm_next = DONE;
      DONE: begin
        v_o = 1'b1;
        if (yumi_i) w_fsm_next = IDLE;
      end
      default: w_fsm_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_r   <= IDLE;
      round_r <= '0;
      state_r <= '0;
    end else begin
      fsm_r <= w_fsm_next;
      if (w_accept) begin
        state_r <= plaintext_i ^ round_keys_i[0:127];
        round_r <= 4'd1;
      end else if (fsm_r == BUSY) begin
        state_r <= w_round_out;
        if (!w_final) round_r <= round_r + 4'd1;
      end
    end
  end

  // The result register doubles as the output; it keeps its value after yumi until the next accept.
  assign ciphertext_o = state_r;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o))
        else $error("aes256_round_engine: yumi_i asserted while v_o=0");
      if (fsm_r == BUSY) begin
        assert (round_r >= 4'd1 && round_r <= 4'(num_rounds_p))
          else $error("aes256_round_engine: round_r out of range in BUSY");
      end
    end
  end

endmodule

// File: tb/tb_aes256_round_engine.sv
// Directed and randomized bench for aes256_round_engine against a GF(2^8)-derived AES-256 model.
module tb_aes256_round_engine;

  logic              clk_i;
  logic              reset_i;
  logic              v_i;
  logic              ready_o;
  logic [0:127]      plaintext_i;
  logic [0:128*15-1] round_keys_i;
  logic              v_o;
  logic [0:127]      ciphertext_o;
  logic              yumi_i;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_m [256];

  aes256_round_engine dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .plaintext_i  (plaintext_i),
    .round_keys_i (round_keys_i),
    .v_o          (v_o),
    .ciphertext_o (ciphertext_o),
    .yumi_i       (yumi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // Standard AES-256 key schedule: 60 words, round key r = words 4r..4r+3.
  function automatic logic [0:1919] expand_key(input logic [255:0] key);
    logic [7:0] w [60][4];
    logic [7:0] t [4];
    logic [7:0] tmp, rcon;
    logic [0:1919] rk;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[255 - 8*(4*i+j) -: 8];
    rcon = 8'h01;
    for (int i = 8; i < 60; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % 8 == 0) begin
        tmp = t[0]; t[0] = t[1]; t[1] = t[2]; t[2] = t[3]; t[3] = tmp;
        for (int j = 0; j < 4; j++) t[j] = sbox_m[t[j]];
        t[0] = t[0] ^ rcon;
        rcon = gmul(rcon, 8'h02);
      end else if (i % 8 == 4) begin
        for (int j = 0; j < 4; j++) t[j] = sbox_m[t[j]];
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-8][j] ^ t[j];
    end
    rk = '0;
    for (int i = 0; i < 60; i++)
      for (int j = 0; j < 4; j++) rk[8*(4*i+j) +: 8] = w[i][j];
    return rk;
  endfunction

  function automatic logic [0:127] aes_model(input logic [0:127] pt, input logic [0:1919] rk);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [0:127] o;
    for (int k = 0; k < 16; k++) s[k] = pt[8*k +: 8] ^ rk[8*k +: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_m[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd < 14) begin
        for (int k = 0; k < 16; k++) t[k] = s[k];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[128*rnd + 8*k +: 8];
    end
    for (int k = 0; k < 16; k++) o[8*k +: 8] = s[k];
    return o;
  endfunction

  // Accept one block, wait for v_o, optionally stall the consumer, then take the result.
  task automatic run_block(input string tag, input logic [0:127] pt, input logic [0:1919] rks,
                           input logic [0:127] exp, input int hold, input bit vi_busy);
    int lat;
    plaintext_i  = pt;
    round_keys_i = rks;
    v_i          = 1'b1;
    check({tag, "_ready_idle"}, ready_o, 1);
    tick();
    if (!vi_busy) v_i = 1'b0;
    lat = 0;
    while (!v_o && lat < 40) begin
      check({tag, "_ready_busy"}, ready_o, 0);
      if (vi_busy) plaintext_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      lat++;
    end
    v_i = 1'b0;
    check({tag, "_latency"}, lat, 14);
    check({tag, "_ct"}, ciphertext_o, exp);
    for (int h = 0; h < hold; h++) begin
      round_keys_i = {60{$urandom()}};
      tick();
      check({tag, "_hold_v"}, v_o, 1);
      check({tag, "_hold_ct"}, ciphertext_o, exp);
      check({tag, "_hold_ready"}, ready_o, 0);
    end
    if (v_o) begin
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
    end
    check({tag, "_post_v"}, v_o, 0);
    check({tag, "_post_ready"}, ready_o, 1);
    check({tag, "_post_ct"}, ciphertext_o, exp);
  endtask

  initial begin
    logic [7:0]    inv;
    logic [0:1919] rk_c3, rk_sp, rk_zero, rk_rand;
    logic [0:127]  pt_c3, pt_sp, pt_rand;
    logic [255:0]  key_rand;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rk_c3   = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    rk_sp   = expand_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    rk_zero = expand_key(256'h0);
    pt_c3   = 128'h00112233445566778899aabbccddeeff;
    pt_sp   = 128'h6bc1bee22e409f96e93d7e117393172a;

    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    plaintext_i = '0; round_keys_i = '0;
    tick();
    tick();
    reset_i = 1'b0;
    check("reset_ready", ready_o, 1);
    check("reset_v", v_o, 0);
    check("reset_ct", ciphertext_o, 0);

    run_block("c3", pt_c3, rk_c3, 128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0);
    run_block("sp800", pt_sp, rk_sp, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 0, 1'b0);
    run_block("zero", 128'h0, rk_zero, 128'hdc95c078a2408989ad48a21492842087, 0, 1'b0);

    run_block("bp", pt_sp, rk_sp, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 20, 1'b0);
    run_block("bp_next", pt_c3, rk_c3, 128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0);

    run_block("vi_busy", pt_c3, rk_c3, 128'h8ea2b7ca516745bfeafc49904b496089, 2, 1'b1);

    plaintext_i = pt_c3; round_keys_i = rk_c3; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    repeat (6) tick();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("midreset_ready", ready_o, 1);
    check("midreset_v", v_o, 0);
    check("midreset_ct", ciphertext_o, 0);
    run_block("after_reset", pt_c3, rk_c3, 128'h8ea2b7ca516745bfeafc49904b496089, 0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      key_rand = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
      pt_rand  = {$urandom(), $urandom(), $urandom(), $urandom()};
      rk_rand  = expand_key(key_rand);
      run_block("rand", pt_rand, rk_rand, aes_model(pt_rand, rk_rand),
                int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
